// File: rtl/scntr_pkg.sv
// Shared encodings for the reload controller: FSM states and timer mode.
package scntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/scntr_reload_ctl.sv
// Sequencer for an external up-counter: preloads ~period, runs to all-ones, ticks.
// Optional one-deep shadow period register: define SCNTR_RELOAD_SHADOW_EN.
//
// state | meaning
// IDLE  | counter held, period writes go straight to the active register
// LOAD  | one cycle parallel-load of ~active into the counter
// RUN   | counter enabled; terminal count ticks and reloads or finishes
module scntr_reload_ctl
  import scntr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_mode,
  input  logic [N-1:0] i_per_d,
  input  logic         i_per_valid,
  output logic         o_per_ready,
  input  logic         i_cnt_cout,
  output logic [N-1:0] o_cnt_d,
  output logic         o_cnt_pl,
  output logic         o_cnt_en,
  output logic         o_tick,
  output logic         o_busy
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_mode;
  logic [N-1:0]   r_active;
  logic [N-1:0]   w_next_per;
  logic           w_pl;
  logic           w_en;
  logic           w_tick;
  logic           w_xfer;
  logic           w_enter_idle;

`ifdef SCNTR_RELOAD_SHADOW_EN
  logic [N-1:0]   r_shadow;
  logic           r_shadow_v;

  assign o_per_ready = (r_state == IDLE) || !r_shadow_v;
  assign w_next_per  = r_shadow_v ? r_shadow : r_active;
`else
  assign o_per_ready = (r_state == IDLE);
  assign w_next_per  = r_active;
`endif

  assign w_xfer       = i_per_valid && o_per_ready;
  assign w_enter_idle = (r_state != IDLE) && (w_state_nxt == IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_pl        = 1'b0;
    w_en        = 1'b0;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_pl        = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_en = 1'b1;
        // STOP outranks a coincident terminal count: no tick, no reload
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else if (i_cnt_cout) begin
          w_tick = 1'b1;
          if (r_mode == MODE_PERIODIC) w_pl = 1'b1;
          else                         w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!i_rstn) begin
      w_pl   = 1'b0;
      w_en   = 1'b0;
      w_tick = 1'b0;
    end
  end

  assign o_cnt_pl = w_pl;
  assign o_cnt_en = w_en;
  assign o_tick   = w_tick;
  assign o_cnt_d  = w_pl ? ~w_next_per : '1;
  assign o_busy   = (r_state != IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_mode   <= MODE_ONESHOT;
      r_active <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && i_start && !i_stop) r_mode <= i_mode;
`ifndef SCNTR_RELOAD_SHADOW_EN
      if (w_xfer) r_active <= i_per_d;
`else
      if (r_state == IDLE) begin
        if (w_xfer) r_active <= i_per_d;
      end else if (w_enter_idle) begin
        // a pending or same-cycle period write survives the abort
        if (w_xfer)          r_active <= i_per_d;
        else if (r_shadow_v) r_active <= r_shadow;
      end else if (w_pl && r_state == RUN && r_shadow_v) begin
        r_active <= r_shadow;
      end
`endif
    end
  end

`ifdef SCNTR_RELOAD_SHADOW_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_shadow   <= '0;
      r_shadow_v <= 1'b0;
    end else if (r_state != IDLE) begin
      if (w_enter_idle) begin
        r_shadow_v <= 1'b0;
      end else if (w_pl && r_state == RUN && r_shadow_v) begin
        r_shadow_v <= 1'b0;
      end else if (w_xfer) begin
        r_shadow   <= i_per_d;
        r_shadow_v <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scntr_reload_ctl.sv
// Bench for scntr_reload_ctl: behavioural expiry-timer model plus directed pins.
module tb_scntr_reload_ctl;
  localparam int N = 8;
`ifdef SCNTR_RELOAD_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0, per_valid = 1'b0;
  logic [N-1:0] per_d = '0;
  logic         per_ready, cnt_pl, cnt_en, tick, busy, cnt_cout;
  logic [N-1:0] cnt_d;
  logic [N-1:0] q;

  scntr_reload_ctl #(.N(N)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_per_d(per_d), .i_per_valid(per_valid), .o_per_ready(per_ready),
    .i_cnt_cout(cnt_cout), .o_cnt_d(cnt_d), .o_cnt_pl(cnt_pl), .o_cnt_en(cnt_en),
    .o_tick(tick), .o_busy(busy)
  );

  // downstream loadable up-counter
  always @(posedge clk) begin
    if (cnt_pl)      q <= cnt_d;
    else if (cnt_en) q <= q + 1'b1;
  end
  assign cnt_cout = cnt_en && (q == '1);

  int n_vec = 0, n_cmp = 0, n_err = 0, cyc = 0;

  // model: a timer that expires 'remain' cycles from now
  bit           m_ok = 1'b0, m_busy = 1'b0, m_load = 1'b0, m_mode = 1'b0, m_sv = 1'b0;
  int           m_remain = 0;
  logic [N-1:0] m_active = '0, m_shadow = '0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic go_idle(input bit xfer, input logic [N-1:0] d);
    m_busy   = 1'b0;
    m_load   = 1'b0;
    m_active = xfer ? d : (m_sv ? m_shadow : m_active);
    m_sv     = 1'b0;
  endtask

  task automatic step(input bit s, input bit p, input bit md, input bit v,
                      input logic [N-1:0] d, input bit rn);
    bit           e_tick, e_pl, e_en, e_rdy, xfer;
    logic [N-1:0] per, e_d;
    @(negedge clk);
    start = s; stop = p; mode = md; per_valid = v; per_d = d; rstn = rn;
    #1;
    cyc++;
    e_rdy  = !m_busy || (SH && !m_sv);
    xfer   = v && e_rdy;
    e_tick = 1'b0; e_pl = 1'b0; e_en = 1'b0;
    per    = m_active;
    if (rn && m_busy) begin
      if (m_load) begin
        e_pl = !p;
      end else begin
        e_en = 1'b1;
        if (!p && m_remain == 0) begin
          e_tick = 1'b1;
          if (m_mode) begin
            e_pl = 1'b1;
            per  = m_sv ? m_shadow : m_active;
          end
        end
      end
    end
    e_d = e_pl ? ~per : '1;
    if (m_ok) begin
      n_vec++;
      chk1("busy", busy, m_busy);
      chk1("per_ready", per_ready, e_rdy);
      chk1("tick", tick, e_tick);
      chk1("cnt_pl", cnt_pl, e_pl);
      chk1("cnt_en", cnt_en, e_en);
      chkd("cnt_d", cnt_d, e_d);
    end
    if (!rn) begin
      m_ok = 1'b1; m_busy = 1'b0; m_load = 1'b0; m_mode = 1'b0; m_sv = 1'b0;
      m_active = '0; m_shadow = '0; m_remain = 0;
    end else if (!m_busy) begin
      if (xfer) m_active = d;
      if (s && !p) begin
        m_busy = 1'b1; m_load = 1'b1; m_mode = md;
      end
    end else if (p) begin
      go_idle(xfer, d);
    end else if (m_load) begin
      m_load   = 1'b0;
      m_remain = int'(m_active);
      if (xfer) begin m_shadow = d; m_sv = 1'b1; end
    end else if (m_remain == 0) begin
      if (m_mode) begin
        m_remain = int'(per);
        m_active = per;
        if (m_sv) m_sv = 1'b0;
        else if (xfer) begin m_shadow = d; m_sv = 1'b1; end
      end else begin
        go_idle(xfer, d);
      end
    end else begin
      m_remain--;
      if (xfer) begin m_shadow = d; m_sv = 1'b1; end
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // steps until a tick is seen; returns its cycle, or -1 when the budget runs out
  task automatic find_tick(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      idle_step();
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic arm(input logic [N-1:0] per, input bit md, output int t0);
    step(1'b0, 1'b0, 1'b0, 1'b1, per, 1'b1);
    step(1'b1, 1'b0, md, 1'b0, '0, 1'b1);
    t0 = cyc;
    idle_step();
  endtask

  task automatic halt();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle_step();
  endtask

  initial begin
    int t0, t1, t2;
    logic [N-1:0] rd;

    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle_step();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", per_ready, 1'b1);
    chkd("rst_d", cnt_d, 8'hFF);
    chk1("rst_pl", cnt_pl, 1'b0);
    chk1("rst_en", cnt_en, 1'b0);

    // one-shot, period 5
    arm(8'd5, 1'b0, t0);
    chk1("os_load_pl", cnt_pl, 1'b1);
    chkd("os_load_d", cnt_d, 8'hFA);
    find_tick(20, t1);
    chki("os_tick_at", t1 - t0, 7);
    idle_step();
    chk1("os_done_busy", busy, 1'b0);

    // periodic, period 3
    arm(8'd3, 1'b1, t0);
    chkd("per_load_d", cnt_d, 8'hFC);
    find_tick(20, t1);
    chki("per_first", t1 - t0, 5);
    for (int k = 0; k < 3; k++) begin
      chk1("per_reload_pl", cnt_pl, 1'b1);
      chkd("per_reload_d", cnt_d, 8'hFC);
      find_tick(20, t2);
      chki("per_spacing", t2 - t1, 4);
      t1 = t2;
    end
    halt();

    // period 0: tick every cycle
    arm(8'd0, 1'b1, t0);
    chkd("zero_load_d", cnt_d, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      idle_step();
      chk1("zero_tick", tick, 1'b1);
      chkd("zero_d", cnt_d, 8'hFF);
    end
    halt();

    // STOP coincident with terminal count
    arm(8'd2, 1'b1, t0);
    idle_step();
    idle_step();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk1("stop_cout", cnt_cout, 1'b1);
    chk1("stop_tick", tick, 1'b0);
    chk1("stop_pl", cnt_pl, 1'b0);
    idle_step();
    chk1("stop_idle", busy, 1'b0);

    if (SH) begin
      arm(8'd3, 1'b1, t0);
      find_tick(20, t1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1);
      chk1("sh_ready_before", per_ready, 1'b1);
      idle_step();
      chk1("sh_ready_full", per_ready, 1'b0);
      find_tick(20, t1);
      chkd("sh_reload_d", cnt_d, 8'hF6);
      idle_step();
      chk1("sh_ready_back", per_ready, 1'b1);
      find_tick(30, t2);
      chki("sh_spacing", t2 - t1, 10);
      halt();
    end

    // reset mid-run, shadow pending where present
    arm(8'd4, 1'b1, t0);
    idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle_step();
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_ready", per_ready, 1'b1);
    chkd("mr_d", cnt_d, 8'hFF);
    chk1("mr_en", cnt_en, 1'b0);
    chk1("mr_tick", tick, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle_step();
    chkd("mr_active0", cnt_d, 8'hFF);
    halt();

    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 10));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, bit'($urandom),
           $urandom_range(0, 3) == 0, rd, $urandom_range(0, 299) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
